// File: rtl/im_boot_loader.sv
// ============================================================================
// im_boot_loader : byte-stream loader for the instruction memory; holds the
// CPU in reset until the whole image has been written.     Revision 1.0
// ============================================================================
`default_nettype none

module im_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [15:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              err_len_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

  state_t              state_q;
  logic [15:0]         len_q;
  logic [15:0]         idx_q;
  logic [7:0]          hi_q;
  logic                in_ready_q;
  logic                im_we_q;
  logic [ADDR_W-1:0]   im_addr_q;
  logic [15:0]         im_wdata_q;
  logic                cpu_hold_q;
  logic                load_done_q;
  logic                err_len_q;

  logic                w_xfer;
  logic [15:0]         w_len;

  assign w_xfer = in_valid_i & in_ready_q;
  assign w_len  = {len_q[15:8], in_data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      hi_q        <= 8'd0;
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= 16'd0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q     <= S_LEN_HI;
            in_ready_q  <= 1'b1;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_len_q   <= 1'b0;
            idx_q       <= 16'd0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            len_q[15:8] <= in_data_i;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            len_q <= w_len;
            if (w_len == 16'd0) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else if ({1'b0, w_len} > C_MAX_WORDS) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              err_len_q  <= 1'b1;
            end else begin
              state_q <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (w_xfer) begin
            hi_q    <= in_data_i;
            state_q <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          // Write strobe and payload are launched here so they are live during WRITE.
          if (w_xfer) begin
            state_q    <= S_WRITE;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b1;
            im_addr_q  <= idx_q[ADDR_W-1:0];
            im_wdata_q <= {hi_q, in_data_i};
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + 16'd1;
          if (idx_q + 16'd1 == len_q) begin
            state_q     <= S_DONE;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            state_q    <= S_DAT_HI;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign im_we_o     = im_we_q;
  assign im_addr_o   = im_addr_q;
  assign im_wdata_o  = im_wdata_q;
  assign cpu_hold_o  = cpu_hold_q;
  assign load_done_o = load_done_q;
  assign err_len_o   = err_len_q;

endmodule

`default_nettype wire

// File: tb/tb_im_boot_loader.sv
// ============================================================================
// tb_im_boot_loader : bench for im_boot_loader using a queue-based image model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_im_boot_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [7:0]        in_data_i = 8'd0;
  logic              in_ready_o;
  logic              im_we_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [15:0]       im_wdata_o;
  logic              cpu_hold_o;
  logic              load_done_o;
  logic              err_len_o;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned wa[$];
  logic [15:0] wd[$];

  im_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .im_we_o     (im_we_o),
    .im_addr_o   (im_addr_o),
    .im_wdata_o  (im_wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .load_done_o (load_done_o),
    .err_len_o   (err_len_o)
  );

  always #5 clk = ~clk;

  // Capture every IM write in the middle of the cycle it is asserted.
  always @(negedge clk) begin
    if (im_we_o) begin
      wa.push_back(int'(im_addr_o));
      wd.push_back(im_wdata_o);
    end
  end

  function automatic byte_q_t mk_stream(input logic [15:0] n, input word_q_t w);
    byte_q_t s;
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[i]) begin
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wa.delete(); wd.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // mode 0: valid always high, 1: toggles 1-0-1-0, 2: random. Returns at the
  // falling edge right after the edge that consumed the last byte.
  task automatic send_bytes(input byte_q_t s, input int mode, output bit ok);
    int i = 0;
    int cyc = 0;
    ok = 1'b1;
    while (i < s.size()) begin
      @(negedge clk);
      case (mode)
        0:       in_valid_i = 1'b1;
        1:       in_valid_i = (cyc % 2 == 0);
        default: in_valid_i = ($urandom_range(99) < 60);
      endcase
      in_data_i = in_valid_i ? s[i] : 8'($urandom);
      if (in_valid_i && in_ready_o) i++;
      cyc++;
      if (cyc > 20000) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({in_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_hold_o, load_done_o, err_len_o}
        !== {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b",
               in_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_hold_o, load_done_o, err_len_o);
    end
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    n_tests++;
    if (in_ready_o !== 1'b0 || cpu_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_over_start: got rdy=%b hold=%b want rdy=0 hold=1", in_ready_o, cpu_hold_o);
    end
  endtask

  task automatic run_image(input string name, input word_q_t w, input int mode, input bit chk_lat);
    bit ok;
    do_reset();
    pulse_start();
    n_tests++;
    if (in_ready_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start: got rdy=%b hold=%b want 1 1", name, in_ready_o, cpu_hold_o);
    end
    send_bytes(mk_stream(16'(w.size()), w), mode, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: stream not consumed", name);
    end
    if (chk_lat) begin
      n_tests++;
      if (im_we_o !== 1'b1 || load_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_lat_we: got we=%b done=%b want we=1 done=0", name, im_we_o, load_done_o);
      end
      @(negedge clk);
      n_tests++;
      if (load_done_o !== 1'b1 || cpu_hold_o !== 1'b0 || im_we_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_lat_done: got done=%b hold=%b we=%b want 1 0 0",
                 name, load_done_o, cpu_hold_o, im_we_o);
      end
    end else begin
      for (int c = 0; c < 5 && !load_done_o; c++) @(negedge clk);
    end
    n_tests++;
    if (load_done_o !== 1'b1 || cpu_hold_o !== 1'b0 || in_ready_o !== 1'b0 || err_len_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_final: got done=%b hold=%b rdy=%b err=%b want 1 0 0 0",
               name, load_done_o, cpu_hold_o, in_ready_o, err_len_o);
    end
    n_tests++;
    if (wa.size() != w.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes want %0d", name, wa.size(), w.size());
    end else begin
      foreach (w[i]) begin
        n_tests++;
        if (wa[i] != i || wd[i] !== w[i]) begin
          n_fail++;
          $display("FAIL %s_write[%0d]: got a=%0d d=%h want a=%0d d=%h", name, i, wa[i], wd[i], i, w[i]);
        end
      end
    end
  endtask

  task automatic test_basic();
    word_q_t w = '{16'h4011, 16'h0122, 16'hB033};
    run_image("basic", w, 0, 1'b1);
  endtask

  task automatic test_stall();
    word_q_t w = '{16'h4011, 16'h0122, 16'hB033};
    run_image("toggle", w, 1, 1'b0);
  endtask

  task automatic test_zero();
    word_q_t w;
    run_image("zero", w, 0, 1'b0);
  endtask

  task automatic test_err_len();
    bit ok;
    byte_q_t s = '{8'h01, 8'h01};
    do_reset();
    pulse_start();
    send_bytes(s, 0, ok);
    n_tests++;
    if (err_len_o !== 1'b1 || cpu_hold_o !== 1'b1 || in_ready_o !== 1'b0 || load_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_state: got err=%b hold=%b rdy=%b done=%b want 1 1 0 0",
               err_len_o, cpu_hold_o, in_ready_o, load_done_o);
    end
    pulse_start();
    n_tests++;
    if (err_len_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b rdy=%b want 0 1", err_len_o, in_ready_o);
    end
  endtask

  task automatic test_abort();
    bit ok;
    word_q_t w;
    byte_q_t hdr = '{8'h00, 8'h04};
    byte_q_t s;
    for (int i = 0; i < 4; i++) w.push_back(16'($urandom));
    do_reset();
    pulse_start();
    send_bytes(hdr, 0, ok);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_tests++;
    if (in_ready_o !== 1'b1 || cpu_hold_o !== 1'b1 || load_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_ignored: got rdy=%b hold=%b done=%b want 1 1 0",
               in_ready_o, cpu_hold_o, load_done_o);
    end
    for (int i = 0; i < 2; i++) begin
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
    end
    send_bytes(s, 0, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (cpu_hold_o !== 1'b1 || in_ready_o !== 1'b0 || im_we_o !== 1'b0 || load_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got hold=%b rdy=%b we=%b done=%b want 1 0 0 0",
               cpu_hold_o, in_ready_o, im_we_o, load_done_o);
    end
    in_valid_i = 1'b1;
    in_data_i  = w[2][15:8];
    repeat (8) @(negedge clk);
    in_valid_i = 1'b0;
    n_tests++;
    if (wa.size() != 2 || wa[0] != 0 || wa[1] != 1 || wd[0] !== w[0] || wd[1] !== w[1]) begin
      n_fail++;
      $display("FAIL abort_writes: got %0d writes want 2 (%h %h)", wa.size(), w[0], w[1]);
    end
  endtask

  task automatic test_full();
    word_q_t w;
    for (int i = 0; i < MAX_WORDS; i++) w.push_back(16'(i));
    run_image("full", w, 0, 1'b1);
    n_tests++;
    if (wa.size() == 0 || wa[wa.size()-1] != 255 || wd[wd.size()-1] !== 16'h00FF) begin
      n_fail++;
      $display("FAIL full_last: got %0d writes, last a=%0d d=%h want a=255 d=00ff",
               wa.size(), (wa.size() > 0) ? wa[wa.size()-1] : 0, (wd.size() > 0) ? wd[wd.size()-1] : 16'h0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      word_q_t w;
      int n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      run_image($sformatf("rand%0d", k), w, 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_err_len();
    test_abort();
    test_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
